// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states,
// access-size encoding and the default wait timeout.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] LSOP_BYTE = 2'b00;
    localparam logic [1:0] LSOP_HALF = 2'b01;
    localparam logic [1:0] LSOP_WORD = 2'b10;

    localparam int DEFAULT_TMO = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
// last_grant = 0 means port 0 was served last, 1 means port 1.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 & (~req1 | last_grant);
    assign gnt1 = req1 & (~req0 | ~last_grant);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port (m0) and a loader port (m1) onto one memory port,
// one transaction at a time, with a timeout on a memory that never answers.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = DEFAULT_TMO
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [1:0]    m0_lsop,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [1:0]    m1_lsop,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_lsop,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    // Counter only has to reach TMO-1; the timeout fires on the cycle after.
    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

    arb_state_t    state, state_next;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          gnt0, gnt1;
    logic          busy, done, tmo_hit;

    rr_arb2 u_rr (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign busy    = (state != IDLE);
    assign done    = busy & mem_ready;
    assign tmo_hit = busy & ~mem_ready & (cnt == CW'(TMO - 1));
    assign mem_en  = busy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Leaving IDLE always passes through BUSYx, so every transaction is
    // followed by at least one IDLE cycle before the next grant.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (gnt0)      state_next = BUSY0;
                else if (gnt1) state_next = BUSY1;
            end
            BUSY0, BUSY1: begin
                if (done || tmo_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            cnt        <= '0;
            mem_we     <= 1'b0;
            mem_lsop   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (gnt0) begin
                    last_grant <= 1'b0;
                    mem_we     <= m0_we;
                    mem_lsop   <= m0_lsop;
                    mem_addr   <= m0_addr;
                    mem_wdata  <= m0_wdata;
                end else if (gnt1) begin
                    last_grant <= 1'b1;
                    mem_we     <= m1_we;
                    mem_lsop   <= m1_lsop;
                    mem_addr   <= m1_addr;
                    mem_wdata  <= m1_wdata;
                end
            end else if (done) begin
                mem_we <= 1'b0;
                if (state == BUSY0) begin
                    m0_ack <= 1'b1;
                    if (!mem_we) m0_rdata <= mem_rdata;
                end else begin
                    m1_ack <= 1'b1;
                    if (!mem_we) m1_rdata <= mem_rdata;
                end
            end else if (tmo_hit) begin
                mem_we <= 1'b0;
                if (state == BUSY0) m0_err <= 1'b1;
                else                m1_err <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, latency, write-field
// stability, timeout, ready-at-deadline and reset during a transaction.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [1:0]    m0_lsop, m1_lsop;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en, mem_we, mem_ready;
    logic [1:0]    mem_lsop;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lsop   (m0_lsop),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lsop   (m1_lsop),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_lsop  (mem_lsop),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("one_pulse_max", 64'($countones({m0_ack, m0_err, m1_ack, m1_err}) <= 1), 64'd1);
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [1:0] lsop,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            m0_req = 1'b1; m0_we = we; m0_lsop = lsop; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_lsop = lsop; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_lsop = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lsop = 0; m1_addr = 0; m1_wdata = 0;
        mem_ready = 0; mem_rdata = 0;

        // Reset state
        tick(); tick();
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 0);
        checkOutput("rst_m0_rdata", m0_rdata, 0);
        checkOutput("rst_m1_rdata", m1_rdata, 0);
        rst = 1'b0;

        // Tie after reset: m0, then m1 on the repeated tie, then m0 again
        applyStimulus(0, 0, LSOP_WORD, 32'h100, 0);
        applyStimulus(1, 0, LSOP_WORD, 32'h200, 0);
        checkOutput("tie_idle_en", mem_en, 0);
        tick();
        checkOutput("tie1_en", mem_en, 1);
        checkOutput("tie1_addr_m0", mem_addr, 32'h100);
        mem_ready = 1;
        tick();
        checkOutput("tie1_m0_ack", m0_ack, 1);
        checkOutput("tie1_m1_ack", m1_ack, 0);
        checkOutput("tie1_gap_en", mem_en, 0);
        mem_ready = 0;
        tick();
        checkOutput("tie2_en", mem_en, 1);
        checkOutput("tie2_addr_m1", mem_addr, 32'h200);
        mem_ready = 1;
        tick();
        checkOutput("tie2_m1_ack", m1_ack, 1);
        checkOutput("tie2_m0_ack", m0_ack, 0);
        mem_ready = 0; m1_req = 0;
        tick();
        checkOutput("tie3_addr_m0", mem_addr, 32'h100);
        mem_ready = 1; m0_req = 0;
        tick();
        checkOutput("tie3_m0_ack", m0_ack, 1);
        mem_ready = 0;

        // m0 read, ready in the second mem_en cycle, ack 4 cycles after req
        applyStimulus(0, 0, LSOP_WORD, 32'h10, 0);
        tick();
        checkOutput("rd_en", mem_en, 1);
        checkOutput("rd_addr", mem_addr, 32'h10);
        checkOutput("rd_we", mem_we, 0);
        tick();
        checkOutput("rd_early_ack", m0_ack, 0);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        checkOutput("rd_ack", m0_ack, 1);
        checkOutput("rd_data", m0_rdata, 32'hDEADBEEF);
        checkOutput("rd_en_off", mem_en, 0);
        m0_req = 0; mem_ready = 0; mem_rdata = 0;
        tick();
        checkOutput("rd_ack_pulse", m0_ack, 0);
        checkOutput("rd_data_hold", m0_rdata, 32'hDEADBEEF);

        // mem_ready while idle is ignored
        mem_ready = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("idle_ready_acks", {m0_ack, m0_err, m1_ack, m1_err}, 0);
            checkOutput("idle_ready_en", mem_en, 0);
        end
        mem_ready = 0;

        // m1 word write, fields held while requester inputs change
        applyStimulus(1, 1, LSOP_WORD, 32'h40, 32'h12345678);
        tick();
        checkOutput("wr_en", mem_en, 1);
        checkOutput("wr_we", mem_we, 1);
        checkOutput("wr_lsop", mem_lsop, LSOP_WORD);
        checkOutput("wr_addr", mem_addr, 32'h40);
        checkOutput("wr_wdata", mem_wdata, 32'h12345678);
        m1_wdata = 32'hFFFFFFFF; m1_addr = 0; m1_we = 0;
        tick();
        checkOutput("wr_wdata_stable", mem_wdata, 32'h12345678);
        checkOutput("wr_addr_stable", mem_addr, 32'h40);
        checkOutput("wr_we_stable", mem_we, 1);
        mem_ready = 1; mem_rdata = 32'hA5A5A5A5;
        tick();
        checkOutput("wr_m1_ack", m1_ack, 1);
        checkOutput("wr_m0_quiet", {m0_ack, m0_err}, 0);
        checkOutput("wr_m1_rdata_kept", m1_rdata, 0);
        m1_req = 0; mem_ready = 0;

        // Timeout, with the requester dropping req mid-transaction
        applyStimulus(0, 0, LSOP_HALF, 32'h80, 0);
        mem_rdata = 32'h11111111;
        tick();
        checkOutput("tmo_en", mem_en, 1);
        checkOutput("tmo_lsop", mem_lsop, LSOP_HALF);
        for (int k = 1; k < TMO; k++) begin
            if (k == 4) m0_req = 0;
            tick();
            checkOutput("tmo_wait_err", m0_err, 0);
            checkOutput("tmo_wait_en", mem_en, 1);
        end
        tick();
        checkOutput("tmo_err", m0_err, 1);
        checkOutput("tmo_no_ack", m0_ack, 0);
        checkOutput("tmo_en_off", mem_en, 0);
        checkOutput("tmo_rdata_kept", m0_rdata, 32'hDEADBEEF);
        tick();
        checkOutput("tmo_err_pulse", m0_err, 0);

        // Ready on the last waiting cycle wins over the timeout
        applyStimulus(0, 0, LSOP_WORD, 32'h84, 0);
        mem_rdata = 32'hCAFEF00D;
        tick();
        for (int k = 1; k < TMO; k++) tick();
        checkOutput("edge_no_err_yet", m0_err, 0);
        mem_ready = 1;
        tick();
        checkOutput("edge_ack", m0_ack, 1);
        checkOutput("edge_no_err", m0_err, 0);
        checkOutput("edge_rdata", m0_rdata, 32'hCAFEF00D);
        mem_ready = 0; m0_req = 0;
        tick();
        checkOutput("edge_after", {m0_ack, m0_err}, 0);

        // Reset during BUSY1 abandons the transaction; next tie goes to m0
        applyStimulus(1, 0, LSOP_WORD, 32'h200, 0);
        tick();
        checkOutput("rb_en", mem_en, 1);
        rst = 1; mem_ready = 1; mem_rdata = 32'h77;
        tick();
        checkOutput("rb_en_off", mem_en, 0);
        checkOutput("rb_no_m1", {m1_ack, m1_err}, 0);
        checkOutput("rb_addr_clr", mem_addr, 0);
        checkOutput("rb_m0_rdata_clr", m0_rdata, 0);
        rst = 0; mem_ready = 0;
        applyStimulus(0, 0, LSOP_WORD, 32'h100, 0);
        tick();
        checkOutput("rb_tie_en", mem_en, 1);
        checkOutput("rb_tie_m0", mem_addr, 32'h100);
        checkOutput("rb_tie_no_m1", {m1_ack, m1_err}, 0);
        mem_ready = 1;
        tick();
        checkOutput("rb_m0_ack", m0_ack, 1);
        checkOutput("rb_m1_ack", m1_ack, 0);
        m0_req = 0; m1_req = 0; mem_ready = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter TMO, 15, max cycles waiting mem_ready before abort.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 m0_req  input  1  CPU access request; held until m0_ack/m0_err.
REQ-007 m0_we  input  1  CPU write (1) / read (0).
REQ-008 m0_lsop  input  2  CPU size, shared BYTE/HALF/WORD encoding.
REQ-009 m0_addr  input  AW  CPU byte address.
REQ-010 m0_wdata  input  DW  CPU write data.
REQ-011 m0_ack  output  1  one-cycle completion pulse to CPU.
REQ-012 m0_err  output  1  one-cycle timeout pulse to CPU.
REQ-013 m0_rdata  output  DW  CPU read data; valid with m0_ack, held until next m0 read.
REQ-014 m1_req/m1_we/m1_lsop/m1_addr/m1_wdata/m1_ack/m1_err/m1_rdata: loader port, same directions and widths as m0 equivalents.
REQ-015 mem_en  output  1  memory access active.
REQ-016 mem_we  output  1  memory write strobe.
REQ-017 mem_lsop  output  2  memory access size.
REQ-018 mem_addr  output  AW  memory address.
REQ-019 mem_wdata  output  DW  memory write data.
REQ-020 mem_rdata  input  DW  memory read data, valid with mem_ready.
REQ-021 mem_ready  input  1  memory completion, sampled only while mem_en=1.

Function
REQ-022 States IDLE, BUSY0, BUSY1; state register plus last_grant bit plus wait counter.
REQ-023 IDLE: only m0_req -> BUSY0; only m1_req -> BUSY1; both -> port != last_grant; none -> IDLE.
REQ-024 On grant, mem_we/mem_lsop/mem_addr/mem_wdata registered from granted port; mem_en=1 from next cycle; last_grant updated; counter cleared.
REQ-025 mem_* fields stay stable for whole BUSY state regardless of requester input changes.
REQ-026 BUSYx with mem_ready=1: mx_ack=1 next cycle, mx_rdata latched from mem_rdata (reads only), mem_en=0, state -> IDLE.
REQ-027 Latency: req sampled in IDLE cycle N -> mem_en cycle N+1 -> ack one cycle after mem_ready; minimum 3 cycles req-to-ack.
REQ-028 Mandatory single IDLE cycle between transactions; no back-to-back grant.
REQ-029 BUSYx counter increments each cycle without mem_ready; reaching TMO -> mx_err pulse, mem_en=0, IDLE, no ack, rdata unchanged.
REQ-030 mem_ready on the TMO cycle wins: ack, no err.
REQ-031 Requester dropping req mid-BUSY: transaction still completes, ack/err still pulses.
REQ-032 mem_ready while mem_en=0 ignored.
REQ-033 Ungranted port never sees ack/err; at most one of m0_ack,m0_err,m1_ack,m1_err high per cycle.

Reset
REQ-034 rst=1: state IDLE, last_grant=1 (m0 wins first tie), counter 0, all outputs 0, rdata registers 0.
REQ-035 rst mid-BUSY: transaction abandoned, mem_en=0 next cycle, no ack/err issued.

Structure
REQ-036 Shared package mem_arb_pkg: state enum, lsop BYTE/HALF/WORD constants (same values as existing byte-enable definitions), default TMO.
REQ-037 Sub-module rr_arb2: combinational 2-way round-robin picker (req0, req1, last_grant -> gnt0, gnt1).

Verification
REQ-038 m0 read addr 0x10, mem_ready 2 cycles after mem_en, mem_rdata 0xDEADBEEF -> m0_ack one cycle, m0_rdata=0xDEADBEEF, 4 cycles req-to-ack.
REQ-039 m0,m1 requests simultaneous first after reset -> m0 granted first, m1 next; repeat tie -> m1 first.
REQ-040 m1 write 0x12345678 WORD to 0x40 -> mem_we=1, mem_addr=0x40, mem_wdata stable until mem_ready; m1_ack; m0 sees nothing.
REQ-041 mem_ready held low -> m0_err exactly TMO cycles after mem_en rise, no ack; mem_ready on cycle TMO -> ack only.
REQ-042 rst pulsed during BUSY1 -> mem_en=0 next cycle, no m1_ack/m1_err, first tie afterwards goes to m0.
